// File: rtl/toggle_sched_pkg.sv
// Shared definitions for the toggle scheduler: state encoding, default widths
// and the index-width helper used by the top level and the arbiter.
package toggle_sched_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int DLY_W_DEF = 4;
    localparam int CNT_W_DEF = 4;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_TOGGLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LOAD   = ST_LOAD,
        S_WAIT   = ST_WAIT,
        S_TOGGLE = ST_TOGGLE,
        S_DONE   = ST_DONE
    } state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the requester after `last` has top
// priority, wrapping modulo N_REQ. The pointer itself lives in the caller.
module rr_arbiter
    import toggle_sched_pkg::*;
#(
    parameter int  N_REQ = N_REQ_DEF,
    localparam int IDX_W = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    int               idx;
    logic [IDX_W-1:0] idx_l;

    // Walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        idx     = 0;
        idx_l   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx   = (int'(last) + k) % N_REQ;
            idx_l = IDX_W'(idx);
            if (req[idx_l]) begin
                win        = '0;
                win[idx_l] = 1'b1;
                win_idx    = idx_l;
            end
        end
    end

endmodule

// File: rtl/toggle_scheduler.sv
// Round-robin sequencer for one shared T flip-flop: runs each granted job's
// delay/toggle sequence on `t` and checks every toggle against the `q` feedback.
module toggle_scheduler
    import toggle_sched_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int DLY_W = DLY_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*DLY_W-1:0] req_dly,
    input  logic [N_REQ*CNT_W-1:0] req_cnt,
    input  logic                   q,
    output logic                   t,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   err
);

    localparam int IDX_W = idx_w(N_REQ);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [IDX_W-1:0] win_idx_q, win_idx_d;
    logic [N_REQ-1:0] win_oh_q, win_oh_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DLY_W-1:0] dly_ctr_q, dly_ctr_d;
    logic [CNT_W-1:0] cnt_ctr_q, cnt_ctr_d;
    logic [CNT_W-1:0] cnt_rem;
    logic             q_exp_q, q_exp_d;
    logic             chk_q, chk_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_win;
    logic [IDX_W-1:0] arb_idx;
    logic [DLY_W-1:0] sel_dly;
    logic [CNT_W-1:0] sel_cnt;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req     (req),
        .last    (last_q),
        .win     (arb_win),
        .win_idx (arb_idx)
    );

    assign sel_dly = req_dly[win_idx_q*DLY_W +: DLY_W];
    assign sel_cnt = req_cnt[win_idx_q*CNT_W +: CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(N_REQ - 1);
            win_idx_q <= '0;
            win_oh_q  <= '0;
            dly_q     <= '0;
            dly_ctr_q <= '0;
            cnt_ctr_q <= '0;
            q_exp_q   <= 1'b0;
            chk_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            dly_q     <= dly_d;
            dly_ctr_q <= dly_ctr_d;
            cnt_ctr_q <= cnt_ctr_d;
            q_exp_q   <= q_exp_d;
            chk_q     <= chk_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        dly_d     = dly_q;
        dly_ctr_d = dly_ctr_q;
        cnt_ctr_d = cnt_ctr_q;
        q_exp_d   = q_exp_q;
        chk_d     = 1'b0;
        // The flop output is compared one cycle after each toggle pulse.
        err_d     = err_q | (chk_q & (q != q_exp_q));
        cnt_rem   = cnt_ctr_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_idx_d = arb_idx;
                    win_oh_d  = arb_win;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                last_d    = win_idx_q;
                dly_d     = sel_dly;
                dly_ctr_d = sel_dly;
                cnt_ctr_d = sel_cnt;
                if (sel_cnt == '0) begin
                    state_d = S_DONE;
                end else if (sel_dly == '0) begin
                    state_d = S_TOGGLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                dly_ctr_d = dly_ctr_q - 1'b1;
                if (dly_ctr_q == DLY_W'(1)) begin
                    state_d = S_TOGGLE;
                end
            end
            S_TOGGLE: begin
                q_exp_d   = ~q;
                chk_d     = 1'b1;
                cnt_ctr_d = cnt_rem;
                if (cnt_rem == '0) begin
                    state_d = S_DONE;
                end else if (dly_q == '0) begin
                    state_d = S_TOGGLE;
                end else begin
                    dly_ctr_d = dly_q;
                    state_d   = S_WAIT;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign t    = (state_q == S_TOGGLE);
    assign gnt  = (state_q == S_LOAD) ? win_oh_q : '0;
    assign done = (state_q == S_DONE) ? win_oh_q : '0;
    assign busy = (state_q != S_IDLE);
    assign err  = err_q;

endmodule
